alu74181_arbiter: RTL and testbench
===================================

# alu74181_arbiter

Round-robin arbiter and sequencer that shares one combinational `alu74181` slice between two requesters. Each requester submits an operation `{s, M, ci, a, b}` over a valid/ready handshake. The block latches the winner's operands onto the ALU inputs, holds them for a programmable settle time, captures `y` and returns it to the same requester over a response handshake. It sits between the requester ports and the shared ALU instance, which is instantiated outside this block.

## Interface
- `SETTLE_CYCLES`, default 1: cycles the ALU inputs are held before `alu_y` is sampled; legal range 1..15.
- `clk` input 1: clock, rising edge.
- `reset` input 1: synchronous, active-low.
- `req0_valid` input 1: requester 0 has an operation.
- `req0_ready` output 1: requester 0 operation accepted this cycle.
- `req0_s` input 4, `req0_m` input 1, `req0_ci` input 1, `req0_a` input 4, `req0_b` input 4: requester 0 operation.
- `req1_valid`, `req1_ready`, `req1_s`, `req1_m`, `req1_ci`, `req1_a`, `req1_b`: same as requester 0, for requester 1.
- `rsp0_valid` output 1: result available for requester 0.
- `rsp0_ready` input 1: requester 0 takes the result.
- `rsp1_valid` output 1, `rsp1_ready` input 1: same as requester 0, for requester 1.
- `rsp_y` output 4: result value, shared by both response ports.
- `alu_s` output 4, `alu_m` output 1, `alu_ci` output 1, `alu_a` output 4, `alu_b` output 4: registered drive to the shared ALU.
- `alu_y` input 4: ALU result.
- `busy` output 1: high whenever the state is not IDLE.
- `ops_done` output 16: count of completed response handshakes; wraps from 0xFFFF to 0.

## Operation
- **States:** IDLE, EXEC, RESP. Reset forces IDLE.
- **Reset values:** all `alu_*` = 0; `rsp_y` = 0; both `rsp*_valid` = 0; `busy` = 0; `ops_done` = 0; `last_grant` = 1; settle counter = 0.
- **Grant (combinational):**
  - Computed only in IDLE with `reset` high.
  - If exactly one requester is valid, it wins.
  - If both are valid, the requester that is not `last_grant` wins.
  - `reqN_ready` = (state == IDLE) & grantN. It is never high for both requesters, and never high outside IDLE or while `reset` is low.
- **IDLE → EXEC:** on an edge where `reqN_valid & reqN_ready`:
  - latch that requester's s, m, ci, a, b into the `alu_*` registers;
  - store the owner id;
  - set `last_grant` = N;
  - load the settle counter with `SETTLE_CYCLES`-1.
- **EXEC:**
  - `alu_*` hold steady.
  - The counter decrements each cycle.
  - On the edge where the counter is 0: `rsp_y` ← `alu_y`, `rsp<owner>_valid` ← 1, go to RESP.
- **RESP:**
  - `rsp<owner>_valid` and `rsp_y` hold until `rsp<owner>_ready` is high at an edge.
  - On that edge: valid ← 0, `ops_done` += 1, go to IDLE.
  - The other response port's ready is ignored.
- **Operand hold:** `alu_*` keep their last operands after completion; they change only on a new acceptance.
- **Requester changes:** a requester that changes operands or drops valid while not ready has no effect.
- **Reset mid-operation:** a `reset` low edge in EXEC or RESP aborts the operation. No response is produced, `ops_done` is unchanged, and all reset values are applied.

## Timing
- **Accept:** handshake at edge T; `alu_*` carry the new operands from T.
- **Capture:** `alu_y` sampled at edge T+`SETTLE_CYCLES`; `rsp*_valid` high in the cycle after that edge.
- **Minimum occupancy:** with `rsp_ready` already high, the response handshake is at edge T+`SETTLE_CYCLES`+1. The next acceptance is at edge T+`SETTLE_CYCLES`+2 at the earliest.
- **Response latency:** `SETTLE_CYCLES` cycles from accept to valid response.
- **Stall:** `rsp_ready` held low keeps the block in RESP indefinitely, and both `reqN_ready` stay 0.

## Test plan
- **Single add:** after reset, req0 {s=1001, m=0, ci=1, a=0011, b=0101}, `SETTLE_CYCLES`=1 → `req0_ready` high for one cycle; `rsp0_valid` one cycle later with `rsp_y`=1000; `ops_done`=1.
- **Fairness:** req0 and req1 valid continuously, both with m=1, s=1011, a=1100, b=1010 → grants alternate 1,0,1,0 (the first tie goes to 0, since `last_grant` resets to 1); every response has `rsp_y`=1000 on the correct port.
- **Back-pressure:** hold `rsp1_ready`=0 for 10 cycles after `rsp1_valid` rises → `rsp_y` stable, `busy`=1, no `req*_ready` pulses; release → `ops_done` increments exactly once.
- **Settle:** `SETTLE_CYCLES`=4, XOR op (m=1, s=0110, a=1111, b=0101) → `rsp_y`=1010, captured exactly 4 edges after accept; `alu_*` constant throughout EXEC.
- **Reset mid-operation:** assert `reset` low during EXEC, then during RESP → no `rsp*_valid`, all outputs at their reset values, `ops_done` unchanged, next grant goes to requester 0.
- **Counter wrap:** preload via 65536 completed ops → `ops_done` wraps 0xFFFF → 0x0000.

Source files
------------

// File: rtl/alu74181_arbiter_if.sv
// rtl/alu74181_arbiter_if.sv - requester, response and shared-ALU signals of the 74181 arbiter
interface alu74181_arbiter_if;
   logic       req0_valid;
   logic       req0_ready;
   logic [3:0] req0_s;
   logic       req0_m;
   logic       req0_ci;
   logic [3:0] req0_a;
   logic [3:0] req0_b;
   logic       req1_valid;
   logic       req1_ready;
   logic [3:0] req1_s;
   logic       req1_m;
   logic       req1_ci;
   logic [3:0] req1_a;
   logic [3:0] req1_b;
   logic       rsp0_valid;
   logic       rsp0_ready;
   logic       rsp1_valid;
   logic       rsp1_ready;
   logic [3:0] rsp_y;
   logic [3:0] alu_s;
   logic       alu_m;
   logic       alu_ci;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [3:0] alu_y;

   modport slave (
      input  req0_valid, req0_s, req0_m, req0_ci, req0_a, req0_b,
      input  req1_valid, req1_s, req1_m, req1_ci, req1_a, req1_b,
      input  rsp0_ready, rsp1_ready, alu_y,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_y,
      output alu_s, alu_m, alu_ci, alu_a, alu_b
   );

   modport master (
      output req0_valid, req0_s, req0_m, req0_ci, req0_a, req0_b,
      output req1_valid, req1_s, req1_m, req1_ci, req1_a, req1_b,
      output rsp0_ready, rsp1_ready, alu_y,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_y,
      input  alu_s, alu_m, alu_ci, alu_a, alu_b
   );
endinterface

// File: rtl/alu74181_arbiter.sv
// rtl/alu74181_arbiter.sv - round-robin sequencer sharing one external 74181 slice between two requesters
module alu74181_arbiter #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic               clk,
   input  logic               reset,
   alu74181_arbiter_if.slave  bus,
   output logic               busy,
   output logic [15:0]        ops_done
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t      state;
   state_t      state_next;
   logic        owner;
   logic        last_grant;
   logic [3:0]  settle_cnt;
   logic [15:0] done_count;
   logic        grant0;
   logic        grant1;
   logic        rsp_take;

   // A tie goes to whichever requester was not served last.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (reset && state == IDLE) begin
         if (bus.req0_valid && bus.req1_valid) begin
            grant0 = last_grant;
            grant1 = ~last_grant;
         end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid;
         end
      end
   end

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;
   assign rsp_take       = owner ? bus.rsp1_ready : bus.rsp0_ready;
   assign busy           = (state != IDLE);
   assign ops_done       = done_count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (grant0 || grant1) state_next = EXEC;
         EXEC: if (settle_cnt == 4'd0) state_next = RESP;
         RESP: if (rsp_take) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         bus.alu_s      <= 4'd0;
         bus.alu_m      <= 1'b0;
         bus.alu_ci     <= 1'b0;
         bus.alu_a      <= 4'd0;
         bus.alu_b      <= 4'd0;
         bus.rsp_y      <= 4'd0;
         bus.rsp0_valid <= 1'b0;
         bus.rsp1_valid <= 1'b0;
         owner          <= 1'b0;
         last_grant     <= 1'b1;
         settle_cnt     <= 4'd0;
         done_count     <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  bus.alu_s  <= grant1 ? bus.req1_s  : bus.req0_s;
                  bus.alu_m  <= grant1 ? bus.req1_m  : bus.req0_m;
                  bus.alu_ci <= grant1 ? bus.req1_ci : bus.req0_ci;
                  bus.alu_a  <= grant1 ? bus.req1_a  : bus.req0_a;
                  bus.alu_b  <= grant1 ? bus.req1_b  : bus.req0_b;
                  owner      <= grant1;
                  last_grant <= grant1;
                  settle_cnt <= SETTLE_LOAD;
               end
            end
            EXEC: begin
               if (settle_cnt == 4'd0) begin
                  bus.rsp_y      <= bus.alu_y;
                  bus.rsp0_valid <= ~owner;
                  bus.rsp1_valid <= owner;
               end else begin
                  settle_cnt <= settle_cnt - 4'd1;
               end
            end
            RESP: begin
               // Only the owner's ready completes the operation.
               if (rsp_take) begin
                  bus.rsp0_valid <= 1'b0;
                  bus.rsp1_valid <= 1'b0;
                  done_count     <= done_count + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu74181_arbiter.sv
// tb/tb_alu74181_arbiter.sv - scoreboard and vector-table bench for alu74181_arbiter
module tb_alu74181_arbiter;
   typedef struct {
      logic [3:0] s;
      logic       m;
      logic       ci;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] y;
   } vec_t;

   typedef struct {
      bit         port;
      logic [3:0] y;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        busy1;
   logic        busy4;
   logic [15:0] ops1;
   logic [15:0] ops4;
   int          checks;
   int          errors;
   exp_t        exp_q[$];
   vec_t        tbl[10];
   vec_t        vf;
   vec_t        vbp;

   always #5 clk = ~clk;

   alu74181_arbiter_if b1();
   alu74181_arbiter_if b4();

   alu74181_arbiter #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .bus(b1), .busy(busy1), .ops_done(ops1)
   );

   alu74181_arbiter #(.SETTLE_CYCLES(4)) dut4 (
      .clk(clk), .reset(reset), .bus(b4), .busy(busy4), .ops_done(ops4)
   );

   // 74181 with active-high data; ci is the active-low carry input.
   function automatic logic [3:0] alu181(input logic [3:0] s, input logic m, input logic ci,
                                         input logic [3:0] a, input logic [3:0] b);
      logic [3:0] r;
      if (m) begin
         case (s)
            4'h0: r = ~a;          4'h1: r = ~(a | b);
            4'h2: r = ~a & b;      4'h3: r = 4'h0;
            4'h4: r = ~(a & b);    4'h5: r = ~b;
            4'h6: r = a ^ b;       4'h7: r = a & ~b;
            4'h8: r = ~a | b;      4'h9: r = ~(a ^ b);
            4'ha: r = b;           4'hb: r = a & b;
            4'hc: r = 4'hf;        4'hd: r = a | ~b;
            4'he: r = a | b;       default: r = a;
         endcase
      end else begin
         case (s)
            4'h0: r = a;                       4'h1: r = a | b;
            4'h2: r = a | ~b;                  4'h3: r = 4'hf;
            4'h4: r = a + (a & ~b);            4'h5: r = (a | b) + (a & ~b);
            4'h6: r = a - b - 4'd1;            4'h7: r = (a & ~b) - 4'd1;
            4'h8: r = a + (a & b);             4'h9: r = a + b;
            4'ha: r = (a | ~b) + (a & b);      4'hb: r = (a & b) - 4'd1;
            4'hc: r = a + a;                   4'hd: r = (a | b) + a;
            4'he: r = (a | ~b) + a;            default: r = a - 4'd1;
         endcase
         r = r + {3'b000, ~ci};
      end
      return r;
   endfunction

   always_comb b1.alu_y = alu181(b1.alu_s, b1.alu_m, b1.alu_ci, b1.alu_a, b1.alu_b);
   always_comb b4.alu_y = alu181(b4.alu_s, b4.alu_m, b4.alu_ci, b4.alu_a, b4.alu_b);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic pop_check(input bit p, input logic [3:0] y);
      exp_t e;
      check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("rsp_port", 32'(p), 32'(e.port));
         check("rsp_y", 32'(y), 32'(e.y));
      end
   endtask

   always @(negedge clk) begin
      if (b1.rsp0_valid && b1.rsp0_ready) pop_check(1'b0, b1.rsp_y);
      if (b1.rsp1_valid && b1.rsp1_ready) pop_check(1'b1, b1.rsp_y);
   end

   task automatic drive_req(input bit p, input logic v, input vec_t o);
      if (p) begin
         b1.req1_valid = v; b1.req1_s = o.s; b1.req1_m = o.m;
         b1.req1_ci = o.ci; b1.req1_a = o.a; b1.req1_b = o.b;
      end else begin
         b1.req0_valid = v; b1.req0_s = o.s; b1.req0_m = o.m;
         b1.req0_ci = o.ci; b1.req0_a = o.a; b1.req0_b = o.b;
      end
   endtask

   task automatic wait_ready(input bit p);
      int n = 0;
      #1;
      while (!(p ? b1.req1_ready : b1.req0_ready) && n < 20) begin
         @(negedge clk); #1; n++;
      end
      check("accept_wait", 32'(n < 20), 32'd1);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk); #1; n++;
      end
      check("drain_wait", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic do_op(input bit p, input vec_t o);
      drive_req(p, 1'b1, o);
      wait_ready(p);
      exp_q.push_back('{p, o.y});
      @(posedge clk); #1;
      drive_req(p, 1'b0, o);
      check("alu_operands", 32'({b1.alu_s, b1.alu_m, b1.alu_ci, b1.alu_a, b1.alu_b}),
            32'({o.s, o.m, o.ci, o.a, o.b}));
      check("busy_exec", 32'(busy1), 32'd1);
      check("ready_drop", 32'({b1.req1_ready, b1.req0_ready}), 32'd0);
      @(posedge clk); #1;
      check("rsp_latency", 32'(p ? b1.rsp1_valid : b1.rsp0_valid), 32'd1);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_alu"}, 32'({b1.alu_s, b1.alu_m, b1.alu_ci, b1.alu_a, b1.alu_b}), 32'd0);
      check({tag, "_rsp_y"}, 32'(b1.rsp_y), 32'd0);
      check({tag, "_rsp_valid"}, 32'({b1.rsp1_valid, b1.rsp0_valid}), 32'd0);
      check({tag, "_busy"}, 32'(busy1), 32'd0);
      check({tag, "_ops_done"}, 32'(ops1), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      checks = 0;
      errors = 0;
      tbl[0] = '{4'b1001, 1'b0, 1'b1, 4'h3, 4'h5, 4'h8};
      tbl[1] = '{4'b1001, 1'b0, 1'b0, 4'h7, 4'h8, 4'h0};
      tbl[2] = '{4'b0110, 1'b1, 1'b1, 4'hf, 4'h5, 4'ha};
      tbl[3] = '{4'b0110, 1'b0, 1'b0, 4'h9, 4'h3, 4'h6};
      tbl[4] = '{4'b0000, 1'b1, 1'b1, 4'h5, 4'h0, 4'ha};
      tbl[5] = '{4'b1110, 1'b1, 1'b1, 4'h4, 4'h3, 4'h7};
      tbl[6] = '{4'b1111, 1'b0, 1'b1, 4'h0, 4'h9, 4'hf};
      tbl[7] = '{4'b1100, 1'b0, 1'b1, 4'h9, 4'h0, 4'h2};
      tbl[8] = '{4'b0011, 1'b1, 1'b1, 4'hf, 4'hf, 4'h0};
      tbl[9] = '{4'b1011, 1'b1, 1'b1, 4'hc, 4'ha, 4'h8};
      vf  = '{4'b1011, 1'b1, 1'b1, 4'hc, 4'ha, 4'h8};
      vbp = '{4'b1001, 1'b0, 1'b1, 4'h2, 4'h4, 4'h6};

      drive_req(1'b0, 1'b0, vf);
      drive_req(1'b1, 1'b0, vf);
      b1.rsp0_ready = 1'b1; b1.rsp1_ready = 1'b1;
      b4.req0_valid = 1'b0; b4.req1_valid = 1'b0;
      b4.req0_s = 4'd0; b4.req0_m = 1'b0; b4.req0_ci = 1'b0; b4.req0_a = 4'd0; b4.req0_b = 4'd0;
      b4.req1_s = 4'd0; b4.req1_m = 1'b0; b4.req1_ci = 1'b0; b4.req1_a = 4'd0; b4.req1_b = 4'd0;
      b4.rsp0_ready = 1'b1; b4.rsp1_ready = 1'b1;

      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("por");
      drive_req(1'b0, 1'b1, vf);
      drive_req(1'b1, 1'b1, vf);
      #1;
      check("ready_in_reset", 32'({b1.req1_ready, b1.req0_ready}), 32'd0);
      drive_req(1'b0, 1'b0, vf);
      drive_req(1'b1, 1'b0, vf);
      reset = 1'b1;

      // Abort in EXEC (requester 1), then in RESP (requester 0).
      drive_req(1'b1, 1'b1, tbl[0]);
      wait_ready(1'b1);
      @(posedge clk); #1;
      drive_req(1'b1, 1'b0, tbl[0]);
      reset = 1'b0;
      @(posedge clk); #1;
      check_reset_state("exec_abort");
      reset = 1'b1;
      b1.rsp0_ready = 1'b0;
      drive_req(1'b0, 1'b1, tbl[0]);
      wait_ready(1'b0);
      @(posedge clk); #1;
      drive_req(1'b0, 1'b0, tbl[0]);
      @(posedge clk); #1;
      check("resp_entered", 32'(b1.rsp0_valid), 32'd1);
      reset = 1'b0;
      @(posedge clk); #1;
      check_reset_state("resp_abort");
      reset = 1'b1;
      b1.rsp0_ready = 1'b1;
      drive_req(1'b0, 1'b1, vf);
      drive_req(1'b1, 1'b1, vf);
      #1;
      check("grant_after_reset", 32'({b1.req1_ready, b1.req0_ready}), 32'd1);
      exp_q.push_back('{1'b0, vf.y});
      @(posedge clk); #1;
      drive_req(1'b0, 1'b0, vf);
      drive_req(1'b1, 1'b0, vf);
      wait_drain();
      check("ops_after_abort", 32'(ops1), 32'd1);

      for (int i = 0; i < 10; i++) begin
         do_op(i[0], tbl[i]);
         wait_drain();
      end
      check("ops_after_table", 32'(ops1), 32'd11);

      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      drive_req(1'b0, 1'b1, vf);
      drive_req(1'b1, 1'b1, vf);
      #1;
      for (int k = 0; k < 4; k++) begin
         int n = 0;
         while (!(b1.req0_ready || b1.req1_ready) && n < 20) begin
            @(negedge clk); #1; n++;
         end
         check("fair_wait", 32'(n < 20), 32'd1);
         check("fair_grant", 32'({b1.req1_ready, b1.req0_ready}), k[0] ? 32'd2 : 32'd1);
         exp_q.push_back('{k[0], vf.y});
         @(posedge clk); #1;
      end
      drive_req(1'b0, 1'b0, vf);
      drive_req(1'b1, 1'b0, vf);
      wait_drain();
      check("ops_after_fair", 32'(ops1), 32'd4);

      b1.rsp1_ready = 1'b0;
      do_op(1'b1, vbp);
      drive_req(1'b0, 1'b1, tbl[2]);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("stall_rsp_y", 32'(b1.rsp_y), 32'(vbp.y));
         check("stall_busy", 32'(busy1), 32'd1);
         check("stall_ready", 32'({b1.req1_ready, b1.req0_ready}), 32'd0);
      end
      drive_req(1'b0, 1'b0, tbl[2]);
      @(posedge clk); #1;
      b1.rsp1_ready = 1'b1;
      wait_drain();
      check("stall_release_ops", 32'(ops1), 32'd5);
      repeat (3) @(posedge clk);
      #1;
      check("stall_ops_once", 32'(ops1), 32'd5);

      force dut1.done_count = 16'hfffe;
      #1;
      release dut1.done_count;
      do_op(1'b0, tbl[0]);
      wait_drain();
      check("ops_ffff", 32'(ops1), 32'h0000ffff);
      do_op(1'b1, tbl[1]);
      wait_drain();
      check("ops_wrap", 32'(ops1), 32'd0);

      b4.req0_s = 4'b0110; b4.req0_m = 1'b1; b4.req0_ci = 1'b1;
      b4.req0_a = 4'hf; b4.req0_b = 4'h5; b4.req0_valid = 1'b1;
      #1;
      check("settle_accept", 32'(b4.req0_ready), 32'd1);
      @(posedge clk); #1;
      b4.req0_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         check("settle_alu", 32'({b4.alu_s, b4.alu_m, b4.alu_ci, b4.alu_a, b4.alu_b}),
               32'({4'b0110, 1'b1, 1'b1, 4'hf, 4'h5}));
         check("settle_valid", 32'(b4.rsp0_valid), 32'(k == 4));
         check("settle_busy", 32'(busy4), 32'd1);
      end
      check("settle_rsp_y", 32'(b4.rsp_y), 32'ha);
      @(posedge clk); #1;
      check("settle_done_valid", 32'(b4.rsp0_valid), 32'd0);
      check("settle_ops", 32'(ops4), 32'd1);

      check("final_queue", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
